// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: walks a 2-input gate through all four input vectors.
// For each vector it drives the inputs for a settle time, samples o1 against
// a truth table, and holds the inputs for a while. At the end of the run it
// reports a pass/fail summary. Every output is registered or decoded from
// registered state, so there is no combinational path from o1 to an output.
module gate_vector_sequencer #(
  parameter int          SETTLE_CYCLES = 2,
  parameter int          HOLD_CYCLES   = 1,
  parameter logic [3:0]  TRUTH         = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o1,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       sample_valid,
  output logic [1:0] sample_idx,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  localparam logic [7:0] SET_LD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_vec,   w_vec_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic       r_pass;
  logic [3:0] r_mask;
  logic [2:0] r_err;
  logic       w_mis;
  logic       w_start_acc;

  // Mismatch detect; an unknown o1 falls into the else branch and counts as a miss.
  always_comb begin
    w_mis = 1'b1;
    if (o1 == TRUTH[r_vec]) w_mis = 1'b0;
  end

  // Next-state, vector index and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_vec_nxt   = 2'd0;
          w_cnt_nxt   = SET_LD;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == 8'd0) w_state_nxt = SAMPLE;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      SAMPLE: begin
        if (HOLD_CYCLES > 0) begin
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = HOLD;
        end else if (r_vec == 2'd3) begin
          w_state_nxt = DONE;
        end else begin
          w_vec_nxt   = r_vec + 2'd1;
          w_cnt_nxt   = SET_LD;
          w_state_nxt = SETTLE;
        end
      end
      HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (r_vec == 2'd3) begin
          w_state_nxt = DONE;
        end else begin
          w_vec_nxt   = r_vec + 2'd1;
          w_cnt_nxt   = SET_LD;
          w_state_nxt = SETTLE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, index and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Result accumulation: cleared on run start, updated in SAMPLE, pass latched in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= 4'd0;
      r_err  <= 3'd0;
      r_pass <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_mask <= 4'd0;
        r_err  <= 3'd0;
      end else if (r_state == SAMPLE && w_mis) begin
        r_mask[r_vec] <= 1'b1;
        r_err         <= r_err + 3'd1;
      end
      if (r_state == DONE) r_pass <= (r_mask == 4'd0);
    end
  end

  assign busy         = (r_state == SETTLE) || (r_state == SAMPLE) || (r_state == HOLD);
  assign a            = busy & r_vec[1];
  assign b            = busy & r_vec[0];
  assign sample_valid = (r_state == SAMPLE);
  assign sample_idx   = sample_valid ? r_vec : 2'd0;
  assign done         = (r_state == DONE);
  assign pass         = r_pass;
  assign fail_mask    = r_mask;
  assign err_count    = r_err;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: several configurations, each
// driving a modelled gate under test, with hand-derived cycle schedules.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // dut0: SETTLE=2 HOLD=1 AND truth; gate is AND or OR depending on mode
  logic s0, o1_0, a0, b0, busy0, sv0, done0, pass0;
  logic [1:0] sidx0;
  logic [3:0] mask0;
  logic [2:0] err0;
  logic mode_or;
  assign o1_0 = mode_or ? (a0 | b0) : (a0 & b0);

  gate_vector_sequencer #(.SETTLE_CYCLES(2), .HOLD_CYCLES(1), .TRUTH(4'b1000)) dut0 (
    .clk(clk), .rst(rst), .start(s0), .o1(o1_0), .a(a0), .b(b0), .busy(busy0),
    .sample_valid(sv0), .sample_idx(sidx0), .done(done0), .pass(pass0),
    .fail_mask(mask0), .err_count(err0));

  // dut1: SETTLE=1 HOLD=0, ideal AND gate
  logic s1, a1, b1, busy1, sv1, done1, pass1;
  logic [1:0] sidx1;
  logic [3:0] mask1;
  logic [2:0] err1;

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .HOLD_CYCLES(0), .TRUTH(4'b1000)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .o1(a1 & b1), .a(a1), .b(b1), .busy(busy1),
    .sample_valid(sv1), .sample_idx(sidx1), .done(done1), .pass(pass1),
    .fail_mask(mask1), .err_count(err1));

  // dut2 (SETTLE=1) and dut3 (SETTLE=3): AND gate whose output lags by 2 cycles
  logic s2, a2, b2, busy2, sv2, done2, pass2;
  logic [1:0] sidx2;
  logic [3:0] mask2;
  logic [2:0] err2;
  logic s3, a3, b3, busy3, sv3, done3, pass3;
  logic [1:0] sidx3;
  logic [3:0] mask3;
  logic [2:0] err3;
  logic d2a = 1'b0, d2b = 1'b0, d3a = 1'b0, d3b = 1'b0;
  always @(posedge clk) begin
    d2a <= a2 & b2; d2b <= d2a;
    d3a <= a3 & b3; d3b <= d3a;
  end

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .HOLD_CYCLES(0), .TRUTH(4'b1000)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .o1(d2b), .a(a2), .b(b2), .busy(busy2),
    .sample_valid(sv2), .sample_idx(sidx2), .done(done2), .pass(pass2),
    .fail_mask(mask2), .err_count(err2));

  gate_vector_sequencer #(.SETTLE_CYCLES(3), .HOLD_CYCLES(0), .TRUTH(4'b1000)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .o1(d3b), .a(a3), .b(b3), .busy(busy3),
    .sample_valid(sv3), .sample_idx(sidx3), .done(done3), .pass(pass3),
    .fail_mask(mask3), .err_count(err3));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_init();
    logic [14:0] got;
    rst = 1'b1; s0 = 0; s1 = 0; s2 = 0; s3 = 0; mode_or = 0;
    step(); step();
    got = {a0, b0, busy0, sv0, sidx0, done0, pass0, mask0, err0};
    n_tests++;
    if (got !== 15'd0) begin
      n_fail++; $display("FAIL reset_init got=%h exp=0", got);
    end
    rst = 1'b0;
    step();
  endtask

  // One full dut0 run: start accepted at edge 0, cycle-by-cycle schedule check,
  // then the summary in cycle 18.
  task automatic run_dut0(input logic orm, input logic [3:0] xm, input logic [2:0] xe,
                          input logic xp, input string nm);
    logic [6:0] got, exp;
    logic [4:0] sg, se;
    logic eb, esv, ed;
    int ev;
    mode_or = orm;
    s0 = 1'b1; step(); s0 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      eb = (c <= 16); ed = (c == 17);
      ev = eb ? (c - 1) / 4 : 0;
      esv = eb && (((c - 1) % 4) == 2);
      exp = {eb & ev[1], eb & ev[0], eb, esv, esv ? ev[1:0] : 2'd0, ed};
      got = {a0, b0, busy0, sv0, sidx0, done0};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s_sched c=%0d got=%b exp=%b", nm, c, got, exp);
      end
      step();
    end
    sg = {busy0, mask0}; se = {1'b0, xm};
    n_tests++;
    if (sg !== se || err0 !== xe || pass0 !== xp) begin
      n_fail++;
      $display("FAIL %s_result busy/mask=%b err=%0d pass=%b exp %b %0d %b",
               nm, sg, err0, pass0, se, xe, xp);
    end
  endtask

  task automatic test_and();
    run_dut0(1'b0, 4'b0000, 3'd0, 1'b1, "and");
  endtask

  task automatic test_or();
    run_dut0(1'b1, 4'b0110, 3'd2, 1'b0, "or");
  endtask

  task automatic test_reset_midrun();
    logic [14:0] got;
    run_dut0(1'b0, 4'b0000, 3'd0, 1'b1, "pre_rst");
    s0 = 1'b1; step(); s0 = 1'b0;
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    got = {a0, b0, busy0, sv0, sidx0, done0, pass0, mask0, err0};
    n_tests++;
    if (got !== 15'd0) begin
      n_fail++; $display("FAIL reset_midrun got=%h exp=0", got);
    end
    step();
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle busy=%b exp=0", busy0);
    end
    run_dut0(1'b1, 4'b0110, 3'd2, 1'b0, "post_rst");
  endtask

  task automatic test_ignored_start();
    int ndone = 0, dcyc = -1, nbusy_late = 0;
    s0 = 1'b1; step();
    for (int c = 1; c <= 30; c++) begin
      s0 = (c == 2 || c == 10);
      if (done0) begin ndone++; dcyc = c; end
      if (c >= 18 && busy0) nbusy_late++;
      step();
    end
    s0 = 1'b0;
    n_tests++;
    if (ndone != 1 || dcyc != 17) begin
      n_fail++; $display("FAIL ignored_start done_count=%0d at=%0d exp 1 at 17", ndone, dcyc);
    end
    n_tests++;
    if (nbusy_late != 0) begin
      n_fail++; $display("FAIL ignored_start_queued busy_cycles=%0d exp 0", nbusy_late);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1;
    logic b18 = 1'bx, b19 = 1'bx;
    s0 = 1'b1; step();
    for (int c = 1; c <= 40; c++) begin
      if (c == 18) b18 = busy0;
      if (c == 19) begin b19 = busy0; s0 = 1'b0; end
      if (done0) begin
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      step();
    end
    n_tests++;
    if (d1 != 17 || d2 != 35) begin
      n_fail++; $display("FAIL back_to_back_done at=%0d,%0d exp 17,35", d1, d2);
    end
    n_tests++;
    if (b18 !== 1'b0 || b19 !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back_busy c18=%b c19=%b exp 0,1", b18, b19);
    end
  endtask

  task automatic test_hold0();
    logic [6:0] got, exp;
    logic eb, esv, ed;
    int ev;
    s1 = 1'b1; step(); s1 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      eb = (c <= 8); ed = (c == 9);
      ev = eb ? (c - 1) / 2 : 0;
      esv = eb && ((c % 2) == 0);
      exp = {eb & ev[1], eb & ev[0], eb, esv, esv ? ev[1:0] : 2'd0, ed};
      got = {a1, b1, busy1, sv1, sidx1, done1};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL hold0_sched c=%0d got=%b exp=%b", c, got, exp);
      end
      step();
    end
    n_tests++;
    if (pass1 !== 1'b1 || mask1 !== 4'd0 || err1 !== 3'd0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL hold0_result pass=%b mask=%b err=%0d exp 1 0000 0", pass1, mask1, err1);
    end
  endtask

  task automatic test_slow_gate();
    bit seen2 = 0, seen3 = 0;
    s2 = 1'b1; s3 = 1'b1; step(); s2 = 1'b0; s3 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (done2) seen2 = 1;
      if (done3) seen3 = 1;
      step();
    end
    n_tests++;
    if (!seen2 || !seen3) begin
      n_fail++; $display("FAIL slow_timeout done2=%0d done3=%0d exp 1 1", seen2, seen3);
    end
    n_tests++;
    if (mask2 !== 4'b1000 || err2 !== 3'd1 || pass2 !== 1'b0) begin
      n_fail++; $display("FAIL slow_settle1 mask=%b err=%0d pass=%b exp 1000 1 0", mask2, err2, pass2);
    end
    n_tests++;
    if (mask3 !== 4'b0000 || err3 !== 3'd0 || pass3 !== 1'b1) begin
      n_fail++; $display("FAIL slow_settle3 mask=%b err=%0d pass=%b exp 0000 0 1", mask3, err3, pass3);
    end
  endtask

  initial begin
    test_reset_init();
    test_and();
    test_or();
    test_reset_midrun();
    test_ignored_start();
    test_back_to_back();
    test_hold0();
    test_slow_gate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Self-checking stimulus controller for a 2-input combinational gate under test (inputs A, B; output O1).
- On start, drives all four input combinations in order, waits a programmable settle time, samples O1 and compares it against an expected truth table.
- Holds each vector for a programmable time, then reports a pass/fail summary.
- Replaces hand-timed initial-block stimulus in gate-level benches; also usable as an on-chip BIST controller for small gates.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is driven before sampling O1; legal range 1..255.
- HOLD_CYCLES, 1, extra cycles each vector is held after sampling; legal range 0..255.
- TRUTH, 4'b1000, expected O1 per vector index: bit i is expected for {a,b}=i. Default is AND.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  level-sampled run request; accepted only in IDLE.
- o1  input  1  observed output of the gate under test.
- a  output  1  gate input A; equals vec_idx[1] while busy, 0 otherwise.
- b  output  1  gate input B; equals vec_idx[0] while busy, 0 otherwise.
- busy  output  1  high in SETTLE, SAMPLE and HOLD.
- sample_valid  output  1  one-cycle pulse in SAMPLE.
- sample_idx  output  2  vector index being sampled; valid when sample_valid=1.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  registered result of the last completed run; 1 if fail_mask==0.
- fail_mask  output  4  bit i set if vector i mismatched in the last or current run.
- err_count  output  3  number of mismatching vectors, 0..4.

Behaviour:
- Reset (rst=1 at a rising edge) forces IDLE, vec_idx=0 and the internal counter to 0. All outputs go to 0: a, b, busy, sample_valid, sample_idx, done, pass, fail_mask, err_count. This applies regardless of state, including mid-run. There is no partial result.
- States: IDLE, SETTLE, SAMPLE, HOLD, DONE. All outputs are registered or decoded from registered state; no combinational path from o1 to any output.
- IDLE: when start=1, clear fail_mask and err_count, set vec_idx=0, load cnt=SETTLE_CYCLES-1, go to SETTLE. pass keeps its old value until DONE.
- SETTLE: a/b driven from vec_idx. When cnt==0, go to SAMPLE; otherwise decrement cnt. Duration is exactly SETTLE_CYCLES cycles.
- SAMPLE: exactly 1 cycle. sample_valid=1 and sample_idx=vec_idx.
  - If o1 != TRUTH[vec_idx], set fail_mask[vec_idx] and increment err_count. The update is visible the following cycle.
  - If HOLD_CYCLES>0: load cnt=HOLD_CYCLES-1, go to HOLD.
  - Else if vec_idx==3: go to DONE.
  - Else: increment vec_idx, load cnt=SETTLE_CYCLES-1, go to SETTLE.
- HOLD: a/b unchanged. When cnt==0, either go to DONE (if vec_idx==3) or increment vec_idx, reload cnt=SETTLE_CYCLES-1 and go to SETTLE. Otherwise decrement cnt.
- DONE: exactly 1 cycle. done=1, busy=0, a=b=0, pass updated from (fail_mask==0). Next state is IDLE unconditionally.
- Start handling:
  - start held high re-launches a new run in the cycle after DONE, i.e. the first IDLE cycle.
  - start in any non-IDLE state is ignored and not queued.
- Timing: a run accepted at edge 0 drives vector 0 from cycle 1. Each vector lasts SETTLE_CYCLES+1+HOLD_CYCLES cycles. done is high in cycle 4*(SETTLE_CYCLES+1+HOLD_CYCLES)+1.
- vec_idx never wraps within a run; it stops at 3.
- Unknown (X/Z) on o1 counts as a mismatch. The bench must check this only in simulation.

Test Plan:
- AND gate, TRUTH=4'b1000, SETTLE=2, HOLD=1; start pulse at cycle 0 -> a,b step 00,01,10,11 every 4 cycles from cycle 1; sample_valid at cycles 3,7,11,15; done at cycle 17; pass=1, fail_mask=0, err_count=0.
- Same config, but o1 is driven from an OR gate -> fail_mask=4'b0110, err_count=2, pass=0 after done.
- HOLD=0, SETTLE=1 -> each vector lasts 2 cycles; done at cycle 9; no HOLD state ever entered.
- Assert rst in cycle 6 of a run -> next cycle all outputs 0, state IDLE; a new start gives a full fresh run with correct results.
- Pulse start at cycles 2 and 10 during a run -> ignored; exactly one done pulse. Holding start high continuously -> back-to-back runs, with done followed by busy two cycles later.
- Slow gate modelled as o1 delayed 2 cycles, SETTLE=1 -> mismatches at the transitioning vectors; SETTLE=3 -> pass=1.
